gcd_controller: RTL

//  FSM that sequences the 16-bit subtract-and-compare GCD datapath.

---
 rtl/gcd_if.sv | 18 +
 rtl/gcd_controller.sv | 96 +++++++++
 2 files changed

// File: rtl/gcd_if.sv
// gcd_if: control/status bundle between the GCD controller and its requester/datapath.
interface gcd_if #(
  parameter int DATA_W = 16,
  parameter int ITER_W = 16
);
  logic start, abort, gt, lt, eq;
  logic [DATA_W-1:0] data_in;
  logic ldA, ldB, sel1, sel2, sel_in, ready, busy, done, err;
  logic [ITER_W-1:0] iter_cnt;
  modport master (
    output start, abort, data_in, gt, lt, eq,
    input ldA, ldB, sel1, sel2, sel_in, ready, busy, done, err, iter_cnt
  );
  modport slave (
    input start, abort, data_in, gt, lt, eq,
    output ldA, ldB, sel1, sel2, sel_in, ready, busy, done, err, iter_cnt
  );
endinterface

// File: rtl/gcd_controller.sv
// gcd_controller: FSM sequencing the subtract-and-compare GCD datapath.
// Define GCD_ITER_COUNT_EN to make iter_cnt live and enable the MAX_ITER limit.
module gcd_controller #(
  parameter int DATA_W   = 16,
  parameter int ITER_W   = 16,
  parameter int MAX_ITER = 0
) (
  input logic  clk,
  input logic  rst_n,
  gcd_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD_B, CALC, DONE} state_t;
  state_t state, next;
  logic za, zb, err_q, set_err, limit, zero_in;
  logic [ITER_W-1:0] iter_q;
  assign zero_in = bus.data_in == DATA_W'(0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      za    <= 1'b0;
      zb    <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= next;
      if (state == IDLE && bus.start) begin
        za    <= zero_in;
        err_q <= 1'b0;
      end
      if (state == LOAD_B && !bus.abort) zb <= zero_in;
      if (set_err) err_q <= 1'b1;
    end
`ifdef GCD_ITER_COUNT_EN
  // A CALC subtract is ldB, or ldA with X=A; the zero-A copy uses X=B and is not counted.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) iter_q <= '0;
    else if (state == IDLE && bus.start) iter_q <= '0;
    else if (state == CALC && (bus.ldB || (bus.ldA && !bus.sel1)) && !(&iter_q)) iter_q <= iter_q + 1'b1;
`else
  assign iter_q = '0;
`endif
  assign limit = MAX_ITER != 0 && iter_q >= ITER_W'(MAX_ITER);
  assign bus.iter_cnt = iter_q;
  always_comb begin
    next       = state;
    bus.ldA    = 1'b0;
    bus.ldB    = 1'b0;
    bus.sel1   = 1'b0;
    bus.sel2   = 1'b0;
    bus.sel_in = 1'b0;
    bus.done   = 1'b0;
    set_err    = 1'b0;
    case (state)
      IDLE:
        if (bus.start) begin
          bus.ldA    = 1'b1;
          bus.sel_in = 1'b1;
          next       = LOAD_B;
        end
      LOAD_B:
        if (bus.abort) next = IDLE;
        else begin
          bus.ldB    = 1'b1;
          bus.sel_in = 1'b1;
          next       = CALC;
        end
      CALC:
        if (bus.abort) next = IDLE;
        else if (za && zb) begin
          set_err = 1'b1;
          next    = DONE;
        end else if (zb) next = DONE;
        else if (za) begin
          bus.ldA  = 1'b1;
          bus.sel1 = 1'b1;
          next     = DONE;
        end else if (bus.eq || limit) begin
          set_err = !bus.eq;
          next    = DONE;
        end else if (bus.gt) begin
          bus.ldA  = 1'b1;
          bus.sel2 = 1'b1;
        end else if (bus.lt) begin
          bus.ldB  = 1'b1;
          bus.sel1 = 1'b1;
        end
      DONE: begin
        bus.done = !bus.abort;
        next     = IDLE;
      end
      default: next = IDLE;
    endcase
  end
  assign bus.ready = state == IDLE;
  assign bus.busy  = state != IDLE;
  assign bus.err   = bus.done && err_q;
endmodule
